// File: rtl/rv32i_apb_master.sv
// Bridges the RV32I core data bus to an APB peripheral region with up to 8 slaves.
// Each request becomes one APB transfer. Decode errors, slave errors and ACCESS timeouts report through oErr.
module rv32i_apb_master #(
  parameter int         NUM_SLV   = 4,
  parameter int         TIMEOUT   = 255,
  parameter logic [3:0] PERI_BASE = 4'h1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iReq,
  input  logic                   iWrEn,
  input  logic [31:0]            iAddr,
  input  logic [31:0]            iWrData,
  input  logic [3:0]             iStrb,
  output logic [31:0]            oRdData,
  output logic                   oReady,
  output logic                   oErr,
  output logic [31:0]            oPaddr,
  output logic                   oPwrite,
  output logic [NUM_SLV-1:0]     oPsel,
  output logic                   oPenable,
  output logic [31:0]            oPwdata,
  output logic [3:0]             oPstrb,
  input  logic [NUM_SLV*32-1:0]  iPrdata,
  input  logic [NUM_SLV-1:0]     iPready,
  input  logic [NUM_SLV-1:0]     iPslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [9:0] CNT_LAST  = 10'(TIMEOUT - 1);
  localparam logic [4:0] SLV_LIMIT = 5'(NUM_SLV);

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        rdata_reg;
  logic [3:0]         strb_reg;
  logic [2:0]         idx_reg;
  logic [9:0]         cnt_reg;
  logic               write_reg;
  logic               err_reg;
  logic               decode_ok;
  logic               timed_out;
  logic               sel_ready;
  logic               sel_slverr;
  logic [31:0]        sel_rdata;
  logic [NUM_SLV-1:0] hit_vec;
  logic [31:0]        masked_rdata [NUM_SLV];

  assign decode_ok = (iAddr[31:28] == PERI_BASE) && ({1'b0, iAddr[15:12]} < SLV_LIMIT);
  assign timed_out = (cnt_reg == CNT_LAST);

  // The one-hot hit vector masks every slave response, so unselected slaves can never leak through.
  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign hit_vec[gi]      = (idx_reg == 3'(gi));
      assign masked_rdata[gi] = iPrdata[32*gi +: 32] & {32{hit_vec[gi]}};
    end
  endgenerate

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_rdata = sel_rdata | masked_rdata[i];
    end
  end

  assign sel_ready  = |(iPready & hit_vec);
  assign sel_slverr = |(iPslverr & hit_vec);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (iReq) state_next = decode_ok ? SETUP : DONE;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (sel_ready || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      strb_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (iReq) begin
            if (decode_ok) begin
              addr_reg  <= iAddr;
              write_reg <= iWrEn;
              wdata_reg <= iWrData;
              strb_reg  <= iWrEn ? iStrb : 4'h0;
              idx_reg   <= iAddr[14:12];
              cnt_reg   <= '0;
            end else begin
              err_reg   <= 1'b1;
              rdata_reg <= '0;
            end
          end
        end
        ACCESS: begin
          // A ready slave wins over a timeout that expires in the same cycle.
          if (sel_ready) begin
            rdata_reg <= write_reg ? 32'h0 : sel_rdata;
            err_reg   <= sel_slverr;
          end else if (timed_out) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        DONE: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oPsel    = (state_reg == SETUP || state_reg == ACCESS) ? hit_vec : '0;
  assign oPenable = (state_reg == ACCESS);
  assign oReady   = (state_reg == DONE);
  assign oRdData  = rdata_reg;
  assign oErr     = err_reg;
  assign oPaddr   = addr_reg;
  assign oPwrite  = write_reg;
  assign oPwdata  = wdata_reg;
  assign oPstrb   = strb_reg;

endmodule

// File: tb/tb_rv32i_apb_master.sv
// Self-checking bench for rv32i_apb_master. The bench plays the core and all APB slaves.
// Expected results come from a transfer-level model of decode, wait-state and timeout rules.
module tb_rv32i_apb_master;

  localparam int NUM_SLV = 4;
  localparam int TIMEOUT = 8;

  logic                  iClk = 1'b0;
  logic                  iRst;
  logic                  iReq;
  logic                  iWrEn;
  logic [31:0]           iAddr;
  logic [31:0]           iWrData;
  logic [3:0]            iStrb;
  logic [31:0]           oRdData;
  logic                  oReady;
  logic                  oErr;
  logic [31:0]           oPaddr;
  logic                  oPwrite;
  logic [NUM_SLV-1:0]    oPsel;
  logic                  oPenable;
  logic [31:0]           oPwdata;
  logic [3:0]            oPstrb;
  logic [NUM_SLV*32-1:0] iPrdata;
  logic [NUM_SLV-1:0]    iPready;
  logic [NUM_SLV-1:0]    iPslverr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  rv32i_apb_master #(
    .NUM_SLV   (NUM_SLV),
    .TIMEOUT   (TIMEOUT),
    .PERI_BASE (4'h1)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iReq     (iReq),
    .iWrEn    (iWrEn),
    .iAddr    (iAddr),
    .iWrData  (iWrData),
    .iStrb    (iStrb),
    .oRdData  (oRdData),
    .oReady   (oReady),
    .oErr     (oErr),
    .oPaddr   (oPaddr),
    .oPwrite  (oPwrite),
    .oPsel    (oPsel),
    .oPenable (oPenable),
    .oPwdata  (oPwdata),
    .oPstrb   (oPstrb),
    .iPrdata  (iPrdata),
    .iPready  (iPready),
    .iPslverr (iPslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rddata"}, oRdData, 32'h0);
    chk({tag, "_ready"}, 32'(oReady), 32'h0);
    chk({tag, "_err"}, 32'(oErr), 32'h0);
    chk({tag, "_paddr"}, oPaddr, 32'h0);
    chk({tag, "_pwrite"}, 32'(oPwrite), 32'h0);
    chk({tag, "_psel"}, 32'(oPsel), 32'h0);
    chk({tag, "_penable"}, 32'(oPenable), 32'h0);
    chk({tag, "_pwdata"}, oPwdata, 32'h0);
    chk({tag, "_pstrb"}, 32'(oPstrb), 32'h0);
  endtask

  // Target slave gets the given response; every other slave drives noise.
  task automatic drive_slaves(input logic valid, input int idx, input logic rdy,
                              input logic slverr, input logic [31:0] rdata);
    for (int s = 0; s < NUM_SLV; s++) begin
      if (valid && s == idx) begin
        iPready[s]           = rdy;
        iPslverr[s]          = slverr;
        iPrdata[32*s +: 32]  = rdata;
      end else begin
        iPready[s]           = 1'($urandom);
        iPslverr[s]          = 1'($urandom);
        iPrdata[32*s +: 32]  = $urandom;
      end
    end
  endtask

  // One core transfer; waits >= TIMEOUT means the slave never answers.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic slverr,
                      input logic [31:0] rdata, input logic keep);
    logic        valid;
    logic        done;
    logic        in_acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          idx, exp_lat, exp_acc, exp_setup;
    int          cyc, acc, n_setup, n_acc;

    valid = (addr[31:28] == 4'h1) && (int'(addr[15:12]) < NUM_SLV);
    idx   = int'(addr[15:12]);
    if (!valid) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_acc = 0; exp_setup = 0;
    end else if (waits >= TIMEOUT) begin
      exp_lat = TIMEOUT + 2; exp_err = 1'b1; exp_rd = 32'h0; exp_acc = TIMEOUT; exp_setup = 1;
    end else begin
      exp_lat = 3 + waits; exp_err = slverr; exp_rd = wr ? 32'h0 : rdata;
      exp_acc = waits + 1; exp_setup = 1;
    end

    iAddr   = addr;
    iWrEn   = wr;
    iWrData = wdata;
    iStrb   = strb;
    iReq    = 1'b1;

    // Back-to-back: the DONE cycle must pass before the new request is taken.
    if (oReady) begin
      @(posedge iClk);
      @(negedge iClk);
      chk("b2b_gap_ready", 32'(oReady), 32'h0);
      chk("b2b_gap_psel", 32'(oPsel), 32'h0);
    end

    cyc = 0; acc = 0; n_setup = 0; n_acc = 0; done = 1'b0;
    drive_slaves(valid, idx, 1'($urandom), slverr, rdata);
    while (!done && cyc < TIMEOUT + 20) begin
      @(posedge iClk);
      cyc++;
      @(negedge iClk);
      chk("psel_onehot", 32'($countones(oPsel) <= 1), 32'h1);
      if (oPsel != '0) begin
        chk("psel_sel", 32'(oPsel), 32'(1) << idx);
        chk("paddr", oPaddr, addr);
        chk("pwrite", 32'(oPwrite), 32'(wr));
        chk("pstrb", 32'(oPstrb), wr ? 32'(strb) : 32'h0);
        if (wr) chk("pwdata", oPwdata, wdata);
        if (oPenable) n_acc++;
        else n_setup++;
      end else begin
        chk("penable_idle", 32'(oPenable), 32'h0);
      end
      if (oReady) begin
        done = 1'b1;
      end else begin
        chk("rddata_quiet", oRdData, 32'h0);
        chk("err_quiet", 32'(oErr), 32'h0);
      end
      in_acc = valid && oPenable && (oPsel[idx[1:0]] === 1'b1);
      drive_slaves(valid, idx, in_acc ? (acc == waits) : 1'($urandom), slverr, rdata);
      if (in_acc) acc++;
    end

    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("ready_err", 32'(oErr), 32'(exp_err));
    chk("ready_rddata", oRdData, exp_rd);
    chk("setup_cycles", 32'(n_setup), 32'(exp_setup));
    chk("access_cycles", 32'(n_acc), 32'(exp_acc));
    $display("xfer addr=%08h wr=%0d waits=%0d lat=%0d err=%0d rd=%08h", addr, wr, waits, cyc, oErr, oRdData);

    if (!keep) begin
      iReq = 1'b0;
      @(posedge iClk);
      @(negedge iClk);
      chk("after_done_ready", 32'(oReady), 32'h0);
    end
  endtask

  initial begin
    logic [3:0]  base;
    logic [3:0]  slv4;
    logic [31:0] raddr;
    int          wsel;
    int          waits;
    logic        found;

    iRst = 1'b0; iReq = 1'b0; iWrEn = 1'b0; iAddr = '0; iWrData = '0; iStrb = '0;
    iPrdata = '0; iPready = '0; iPslverr = '0;

    #2;
    check_all_zero("reset");
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    check_all_zero("post_reset");

    // Read slave 2, zero wait.
    xfer(32'h1000_2004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Write slave 0, two wait states.
    xfer(32'h1000_0010, 1'b1, 32'h1234_5678, 4'b0011, 2, 1'b0, 32'hA5A5_5A5A, 1'b0);
    // Decode errors: slave index out of range, then wrong region.
    xfer(32'h1000_7000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222, 1'b0);
    xfer(32'h2000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h3333_4444, 1'b0);
    // Timeout, last-chance ready, and slave error.
    xfer(32'h1000_3000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_6666, 1'b0);
    xfer(32'h1000_3004, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h7777_8888, 1'b0);
    xfer(32'h1000_1008, 1'b0, 32'h0, 4'h0, 1, 1'b1, 32'h9999_AAAA, 1'b0);

    // Reset asserted in the middle of ACCESS.
    iAddr = 32'h1000_2000; iWrEn = 1'b0; iWrData = 32'h0; iStrb = 4'h0; iReq = 1'b1;
    iPready = '0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge iClk);
      if (oPenable) found = 1'b1;
    end
    chk("rst_reach_access", 32'(found), 32'h1);
    #1 iRst = 1'b0;
    #1 check_all_zero("mid_reset");
    iReq = 1'b0;
    @(negedge iClk);
    chk("mid_reset_no_ready", 32'(oReady), 32'h0);
    iRst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge iClk);
      chk("post_release_no_ready", 32'(oReady), 32'h0);
    end
    xfer(32'h1000_1000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Back-to-back with iReq held.
    xfer(32'h1000_2008, 1'b1, 32'hFEED_0001, 4'b1100, 1, 1'b0, 32'h0, 1'b1);
    xfer(32'h1000_300C, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0F0F_0F0F, 1'b0);

    // Randomized transfers, including boundary wait counts and decode misses.
    for (int n = 0; n < 40; n++) begin
      base  = ($urandom_range(0, 9) == 0) ? 4'h2 : 4'h1;
      slv4  = 4'($urandom_range(0, 5));
      raddr = {base, 12'($urandom), slv4, 12'($urandom)};
      wsel  = $urandom_range(0, 5);
      waits = (wsel < 4) ? wsel : ((wsel == 4) ? TIMEOUT - 1 : TIMEOUT);
      xfer(raddr, 1'($urandom), $urandom, 4'($urandom), waits, 1'($urandom), $urandom,
           1'($urandom));
    end
    iReq = 1'b0;
    repeat (2) @(negedge iClk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
